am_query_arbiter: RTL and testbench

// - Shares one associative_memory instance between NUM_REQ query sources (per-modality or fused encoders).
// - Round-robin arbitration; forwards one query hypervector at a time over the AM valid/ready handshake.
// - Waits for the A/V label+distance result and returns it to the granted requester only.
// - Timeout watchdog guards against a stalled AM; sits between the encoder stage and associative_memory.

---
 rtl/am_query_arbiter_pkg.sv | 23 ++
 rtl/am_query_arbiter_rr_arbiter.sv | 33 +++
 rtl/am_query_arbiter.sv | 172 +++++++++++++++++
 tb/tb_am_query_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_query_arbiter_pkg.sv
// Shared constants and types for the associative-memory query arbiter.
// Holds the HV/label/distance widths and the 2-bit arbiter state encoding.
package am_query_arbiter_pkg;

    localparam int HV_DIMENSION   = 64;
    localparam int LABEL_WIDTH    = 4;
    localparam int DISTANCE_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arbState_t;

    function automatic int ceilLog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/am_query_arbiter_rr_arbiter.sv
// Combinational round-robin pick: scans requesters starting just after the
// last-served index and returns the first valid one as one-hot and as index.
module rr_arbiter
    import am_query_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
)(
    input  logic [NUM_REQ-1:0]  ReqValid_SI,
    input  logic [ID_WIDTH-1:0] Ptr_DI,
    output logic [NUM_REQ-1:0]  Grant_SO,
    output logic [ID_WIDTH-1:0] GrantId_DO,
    output logic                AnyValid_SO
);

    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        Grant_SO    = '0;
        GrantId_DO  = '0;
        AnyValid_SO = 1'b0;
        idx         = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_WIDTH'((int'(Ptr_DI) + off) % NUM_REQ);
            if (!AnyValid_SO && ReqValid_SI[idx]) begin
                AnyValid_SO   = 1'b1;
                Grant_SO[idx] = 1'b1;
                GrantId_DO    = idx;
            end
        end
    end

endmodule

// File: rtl/am_query_arbiter.sv
// Shares one associative memory between NUM_REQ query sources: round-robin
// accept, forward one query, wait (with watchdog) and return the result.
module am_query_arbiter
    import am_query_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
)(
    input  logic                             Clk_CI,
    input  logic                             Reset_RBI,
    input  logic [NUM_REQ-1:0]               ReqValid_SI,
    output logic [NUM_REQ-1:0]               ReqReady_SO,
    input  logic [NUM_REQ*HV_DIMENSION-1:0]  ReqHv_DI,
    output logic [NUM_REQ-1:0]               RspValid_SO,
    input  logic [NUM_REQ-1:0]               RspReady_SI,
    output logic [LABEL_WIDTH-1:0]           RspLabel_A_DO,
    output logic [LABEL_WIDTH-1:0]           RspLabel_V_DO,
    output logic [DISTANCE_WIDTH-1:0]        RspDist_A_DO,
    output logic [DISTANCE_WIDTH-1:0]        RspDist_V_DO,
    output logic                             RspError_SO,
    output logic                             AmValid_SO,
    input  logic                             AmReady_SI,
    output logic [HV_DIMENSION-1:0]          AmHv_DO,
    input  logic                             AmRspValid_SI,
    output logic                             AmRspReady_SO,
    input  logic [LABEL_WIDTH-1:0]           AmLabel_A_DI,
    input  logic [LABEL_WIDTH-1:0]           AmLabel_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]        AmDist_A_DI,
    input  logic [DISTANCE_WIDTH-1:0]        AmDist_V_DI,
    output logic                             Busy_SO,
    output logic                             TimeoutFlag_SO,
    output logic [CNT_WIDTH-1:0]             QueryCount_DO
);

    localparam int TMR_W = ceilLog2(TIMEOUT_CYCLES);

    arbState_t state, stateNext;

    logic [NUM_REQ-1:0]        grant;
    logic [ID_WIDTH-1:0]       grantId;
    logic                      anyValid;
    logic [HV_DIMENSION-1:0]   queryHv_p0;
    logic [ID_WIDTH-1:0]       id_p0;
    logic [ID_WIDTH-1:0]       ptr;
    logic [TMR_W-1:0]          timer;
    logic [LABEL_WIDTH-1:0]    labelA_p1, labelV_p1;
    logic [DISTANCE_WIDTH-1:0] distA_p1, distV_p1;
    logic                      rspError_p1;
    logic                      timeoutFlag;
    logic [CNT_WIDTH-1:0]      queryCount;
    logic                      timeoutHit;
    logic                      rspAccept;
    logic                      inRespond;

    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) uRrArbiter (
        .ReqValid_SI (ReqValid_SI),
        .Ptr_DI      (ptr),
        .Grant_SO    (grant),
        .GrantId_DO  (grantId),
        .AnyValid_SO (anyValid)
    );

    assign timeoutHit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign rspAccept  = RspReady_SI[id_p0];
    assign inRespond  = (state == ST_RESPOND);

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) state <= ST_IDLE;
        else            state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        ReqReady_SO   = '0;
        AmValid_SO    = 1'b0;
        AmRspReady_SO = 1'b0;
        RspValid_SO   = '0;
        case (state)
            ST_IDLE: begin
                ReqReady_SO = grant;
                if (anyValid) stateNext = ST_ISSUE;
            end
            ST_ISSUE: begin
                AmValid_SO = 1'b1;
                if (AmReady_SI) stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                AmRspReady_SO = 1'b1;
                if (AmRspValid_SI || timeoutHit) stateNext = ST_RESPOND;
            end
            ST_RESPOND: begin
                RspValid_SO = NUM_REQ'(1) << id_p0;
                if (rspAccept) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // p0: query captured at accept; p1: AM result (or timeout filler) captured in WAIT
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            queryHv_p0  <= '0;
            id_p0       <= '0;
            ptr         <= ID_WIDTH'(NUM_REQ - 1);
            timer       <= '0;
            labelA_p1   <= '0;
            labelV_p1   <= '0;
            distA_p1    <= '0;
            distV_p1    <= '0;
            rspError_p1 <= 1'b0;
            timeoutFlag <= 1'b0;
            queryCount  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (anyValid) begin
                        queryHv_p0 <= ReqHv_DI[int'(grantId)*HV_DIMENSION +: HV_DIMENSION];
                        id_p0      <= grantId;
                    end
                end
                ST_ISSUE: begin
                    if (AmReady_SI) timer <= '0;
                end
                ST_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    // A result arriving on the timeout cycle still wins
                    if (AmRspValid_SI) begin
                        labelA_p1   <= AmLabel_A_DI;
                        labelV_p1   <= AmLabel_V_DI;
                        distA_p1    <= AmDist_A_DI;
                        distV_p1    <= AmDist_V_DI;
                        rspError_p1 <= 1'b0;
                    end else if (timeoutHit) begin
                        labelA_p1   <= '1;
                        labelV_p1   <= '1;
                        distA_p1    <= '1;
                        distV_p1    <= '1;
                        rspError_p1 <= 1'b1;
                        timeoutFlag <= 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (rspAccept) begin
                        ptr <= id_p0;
                        if (!rspError_p1) queryCount <= satInc(queryCount);
                    end
                end
                default: ;
            endcase
        end
    end

    assign AmHv_DO        = queryHv_p0;
    assign RspLabel_A_DO  = inRespond ? labelA_p1 : '0;
    assign RspLabel_V_DO  = inRespond ? labelV_p1 : '0;
    assign RspDist_A_DO   = inRespond ? distA_p1  : '0;
    assign RspDist_V_DO   = inRespond ? distV_p1  : '0;
    assign RspError_SO    = inRespond & rspError_p1;
    assign Busy_SO        = (state != ST_IDLE);
    assign TimeoutFlag_SO = timeoutFlag;
    assign QueryCount_DO  = queryCount;

endmodule

// File: tb/tb_am_query_arbiter.sv
// Directed and randomized bench for am_query_arbiter against a transaction-level
// model of the round-robin order, watchdog timing and saturating counter.
module tb_am_query_arbiter;
    import am_query_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int T  = 12;
    localparam int CW = 4;
    localparam int HV = HV_DIMENSION;

    logic                       Clk_CI = 1'b0;
    logic                       Reset_RBI = 1'b0;
    logic [NR-1:0]              ReqValid_SI = '0;
    logic [NR-1:0]              ReqReady_SO;
    logic [NR*HV-1:0]           ReqHv_DI = '0;
    logic [NR-1:0]              RspValid_SO;
    logic [NR-1:0]              RspReady_SI = '0;
    logic [LABEL_WIDTH-1:0]     RspLabel_A_DO, RspLabel_V_DO;
    logic [DISTANCE_WIDTH-1:0]  RspDist_A_DO, RspDist_V_DO;
    logic                       RspError_SO;
    logic                       AmValid_SO;
    logic                       AmReady_SI = 1'b0;
    logic [HV-1:0]              AmHv_DO;
    logic                       AmRspValid_SI = 1'b0;
    logic                       AmRspReady_SO;
    logic [LABEL_WIDTH-1:0]     AmLabel_A_DI = '0, AmLabel_V_DI = '0;
    logic [DISTANCE_WIDTH-1:0]  AmDist_A_DI = '0, AmDist_V_DI = '0;
    logic                       Busy_SO;
    logic                       TimeoutFlag_SO;
    logic [CW-1:0]              QueryCount_DO;

    am_query_arbiter #(
        .NUM_REQ        (NR),
        .ID_WIDTH       (2),
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (CW)
    ) dut (
        .Clk_CI         (Clk_CI),
        .Reset_RBI      (Reset_RBI),
        .ReqValid_SI    (ReqValid_SI),
        .ReqReady_SO    (ReqReady_SO),
        .ReqHv_DI       (ReqHv_DI),
        .RspValid_SO    (RspValid_SO),
        .RspReady_SI    (RspReady_SI),
        .RspLabel_A_DO  (RspLabel_A_DO),
        .RspLabel_V_DO  (RspLabel_V_DO),
        .RspDist_A_DO   (RspDist_A_DO),
        .RspDist_V_DO   (RspDist_V_DO),
        .RspError_SO    (RspError_SO),
        .AmValid_SO     (AmValid_SO),
        .AmReady_SI     (AmReady_SI),
        .AmHv_DO        (AmHv_DO),
        .AmRspValid_SI  (AmRspValid_SI),
        .AmRspReady_SO  (AmRspReady_SO),
        .AmLabel_A_DI   (AmLabel_A_DI),
        .AmLabel_V_DI   (AmLabel_V_DI),
        .AmDist_A_DI    (AmDist_A_DI),
        .AmDist_V_DI    (AmDist_V_DI),
        .Busy_SO        (Busy_SO),
        .TimeoutFlag_SO (TimeoutFlag_SO),
        .QueryCount_DO  (QueryCount_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    int total = 0;
    int bad   = 0;

    // Reference model: last-served index, delivered-result count, sticky flag
    int          mPtr;
    int          mCount;
    bit          mFlag;
    bit          pending [NR];
    logic [63:0] hv [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic modelReset();
        mPtr   = NR - 1;
        mCount = 0;
        mFlag  = 1'b0;
    endtask

    task automatic applyReq();
        for (int i = 0; i < NR; i++) begin
            ReqValid_SI[i]         = pending[i];
            ReqHv_DI[i*HV +: HV]   = hv[i];
        end
    endtask

    task automatic addReq(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) begin
            if (mask[i] && !pending[i]) begin
                pending[i] = 1'b1;
                hv[i]      = {$urandom, $urandom};
            end
        end
    endtask

    function automatic int pickWinner();
        for (int off = 1; off <= NR; off++) begin
            if (pending[(mPtr + off) % NR]) return (mPtr + off) % NR;
        end
        return -1;
    endfunction

    // Asynchronous reset asserted between clock edges
    task automatic asyncReset();
        #3;
        Reset_RBI = 1'b0;
        #1;
        chk("rst_amvalid", AmValid_SO, 0);
        chk("rst_rspvalid", RspValid_SO, 0);
        chk("rst_busy", Busy_SO, 0);
        chk("rst_count", QueryCount_DO, 0);
        chk("rst_flag", TimeoutFlag_SO, 0);
        chk("rst_label", RspLabel_A_DO, 0);
        tick();
        Reset_RBI = 1'b1;
        modelReset();
    endtask

    // mode: 0 = AM answers after waitDly cycles, 1 = AM stalls, 2 = AM answers on timeout cycle
    task automatic runTx(input int issueStall, input int mode, input int waitDly,
                         input int rspHold, input logic [NR-1:0] holdMask, input bit abortWait,
                         input logic [LABEL_WIDTH-1:0] rA, input logic [LABEL_WIDTH-1:0] rV,
                         input logic [DISTANCE_WIDTH-1:0] dA, input logic [DISTANCE_WIDTH-1:0] dV);
        int w;
        logic [63:0] expHv;
        logic [LABEL_WIDTH-1:0] eA, eV;
        logic [DISTANCE_WIDTH-1:0] eDA, eDV;
        bit eErr;
        w = pickWinner();
        applyReq();
        #1;
        chk("idle_busy", Busy_SO, 0);
        chk("grant", ReqReady_SO, 64'(1) << w);
        chk("idle_amvalid", AmValid_SO, 0);
        expHv = hv[w];
        tick();
        pending[w] = 1'b0;
        applyReq();
        #1;
        chk("issue_amvalid", AmValid_SO, 1);
        chk("issue_hv", AmHv_DO, expHv);
        chk("issue_noready", ReqReady_SO, 0);
        chk("issue_busy", Busy_SO, 1);
        for (int i = 0; i < issueStall; i++) begin
            tick();
            chk("stall_amvalid", AmValid_SO, 1);
            chk("stall_hv", AmHv_DO, expHv);
        end
        AmReady_SI = 1'b1;
        tick();
        AmReady_SI = 1'b0;
        #1;
        chk("wait_amvalid", AmValid_SO, 0);
        chk("wait_amrspready", AmRspReady_SO, 1);
        if (abortWait) begin
            tick();
            tick();
            asyncReset();
            return;
        end
        eA = rA; eV = rV; eDA = dA; eDV = dV; eErr = 1'b0;
        if (mode == 1) begin
            for (int c = 0; c < T; c++) begin
                chk("to_norsp", RspValid_SO, 0);
                tick();
            end
            eA = '1; eV = '1; eDA = '1; eDV = '1; eErr = 1'b1;
            mFlag = 1'b1;
        end else begin
            for (int c = 0; c < ((mode == 2) ? T - 1 : waitDly); c++) begin
                chk("wait_norsp", RspValid_SO, 0);
                tick();
            end
            AmRspValid_SI = 1'b1;
            AmLabel_A_DI = rA; AmLabel_V_DI = rV; AmDist_A_DI = dA; AmDist_V_DI = dV;
            tick();
            AmRspValid_SI = 1'b0;
            AmLabel_A_DI = LABEL_WIDTH'($urandom); AmLabel_V_DI = LABEL_WIDTH'($urandom);
            AmDist_A_DI = DISTANCE_WIDTH'($urandom); AmDist_V_DI = DISTANCE_WIDTH'($urandom);
        end
        addReq(holdMask);
        applyReq();
        for (int h = 0; h <= rspHold; h++) begin
            RspReady_SI = NR'($urandom) & ~(NR'(1) << w);
            if (h == rspHold) RspReady_SI = RspReady_SI | (NR'(1) << w);
            #1;
            chk("rsp_valid", RspValid_SO, 64'(1) << w);
            chk("rsp_labA", RspLabel_A_DO, eA);
            chk("rsp_labV", RspLabel_V_DO, eV);
            chk("rsp_distA", RspDist_A_DO, eDA);
            chk("rsp_distV", RspDist_V_DO, eDV);
            chk("rsp_err", RspError_SO, eErr);
            chk("rsp_noready", ReqReady_SO, 0);
            tick();
        end
        RspReady_SI = '0;
        mPtr = w;
        if (!eErr) mCount = (mCount + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mCount + 1;
        #1;
        chk("post_rspvalid", RspValid_SO, 0);
        chk("post_label", {RspLabel_A_DO, RspLabel_V_DO, RspDist_A_DO, RspDist_V_DO}, 0);
        chk("post_err", RspError_SO, 0);
        chk("post_count", QueryCount_DO, 64'(mCount));
        chk("post_flag", TimeoutFlag_SO, mFlag);
        chk("post_busy", Busy_SO, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            pending[i] = 1'b0;
            hv[i]      = '0;
        end
        modelReset();
        Reset_RBI = 1'b0;
        repeat (3) @(posedge Clk_CI);
        #1;
        Reset_RBI = 1'b1;
        #1;
        chk("init_busy", Busy_SO, 0);
        chk("init_ready", ReqReady_SO, 0);
        chk("init_amvalid", AmValid_SO, 0);
        chk("init_rspvalid", RspValid_SO, 0);
        chk("init_count", QueryCount_DO, 0);
        chk("init_flag", TimeoutFlag_SO, 0);

        // Single requester 1, AM returns A=1 V=0
        addReq(3'b010);
        runTx(0, 0, 2, 1, 3'b000, 1'b0, 4'd1, 4'd0, 7'd17, 7'd42);

        // All three requesting: rotation from reset is 0,1,2,0,1,2
        tick();
        asyncReset();
        for (int q = 0; q < 6; q++) begin
            addReq(3'b111);
            runTx($urandom % 3, 0, $urandom % (T - 1), $urandom % 3, 3'b000, 1'b0,
                  LABEL_WIDTH'($urandom), LABEL_WIDTH'($urandom),
                  DISTANCE_WIDTH'($urandom), DISTANCE_WIDTH'($urandom));
        end
        chk("count_six", QueryCount_DO, 6);

        // Stalled AM: forced error after exactly T wait cycles, count unchanged
        addReq(3'b001);
        runTx(1, 1, 0, 0, 3'b000, 1'b0, 4'd0, 4'd0, 7'd0, 7'd0);
        chk("count_after_to", QueryCount_DO, 6);
        chk("flag_after_to", TimeoutFlag_SO, 1);

        // Result on the timeout cycle wins; flag stays clear
        tick();
        asyncReset();
        for (int i = 0; i < NR; i++) pending[i] = 1'b0;
        addReq(3'b100);
        runTx(0, 2, 0, 0, 3'b000, 1'b0, 4'd5, 4'd9, 7'd3, 7'd100);
        chk("flag_race", TimeoutFlag_SO, 0);

        // Response withheld 10 cycles while requester 0 waits
        addReq(3'b010);
        runTx(0, 0, 1, 10, 3'b001, 1'b0, 4'd7, 4'd2, 7'd11, 7'd12);

        // Reset mid-WAIT, then next grant goes to requester 0
        runTx(0, 0, 0, 0, 3'b000, 1'b1, 4'd0, 4'd0, 7'd0, 7'd0);
        addReq(3'b111);
        applyReq();
        #1;
        chk("after_abort_grant", ReqReady_SO, 3'b001);
        runTx(0, 0, 0, 0, 3'b000, 1'b0, 4'd3, 4'd4, 7'd5, 7'd6);

        // Random traffic; the 4-bit counter saturates along the way
        for (int q = 0; q < 40; q++) begin
            int mode;
            mode = ($urandom % 10 == 0) ? 1 : (($urandom % 10 == 0) ? 2 : 0);
            addReq(NR'($urandom));
            if (pickWinner() < 0) addReq(NR'(1) << ($urandom % NR));
            runTx($urandom % 3, mode, $urandom % (T - 1), $urandom % 4, NR'($urandom), 1'b0,
                  LABEL_WIDTH'($urandom), LABEL_WIDTH'($urandom),
                  DISTANCE_WIDTH'($urandom), DISTANCE_WIDTH'($urandom));
        end
        chk("final_count", QueryCount_DO, 64'(mCount));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
